// File: rtl/vga_pkg.sv
// Shared VGA definitions: fetch arbiter state encoding and 800x600@72Hz timing constants.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

  // Horizontal total of 1040 pixel clocks bounds the prefetch window per line.
  localparam int VGA_H_VISIBLE     = 800;
  localparam int VGA_H_FRONT_PORCH = 56;
  localparam int VGA_H_SYNC_PULSE  = 120;
  localparam int VGA_H_BACK_PORCH  = 64;
  localparam int VGA_H_TOTAL       = VGA_H_VISIBLE + VGA_H_FRONT_PORCH
                                   + VGA_H_SYNC_PULSE + VGA_H_BACK_PORCH;

  localparam int VGA_V_VISIBLE     = 600;
  localparam int VGA_V_FRONT_PORCH = 37;
  localparam int VGA_V_SYNC_PULSE  = 6;
  localparam int VGA_V_BACK_PORCH  = 23;
  localparam int VGA_V_TOTAL       = VGA_V_VISIBLE + VGA_V_FRONT_PORCH
                                   + VGA_V_SYNC_PULSE + VGA_V_BACK_PORCH;

endpackage

// File: rtl/vga_slot_counter.sv
// Wrap counter that marks every WRITER_SLOT-th fetch cycle as a writer slot.
module vga_slot_counter #(
  parameter int WRITER_SLOT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic slot
);

  localparam int CNT_W = $clog2(WRITER_SLOT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WRITER_SLOT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign slot = (cnt == LAST);

endmodule

// File: rtl/vga_fb_arbiter.sv
// Arbitrates a single-port framebuffer between display line prefetch (priority)
// and a pixel writer that gets periodic slots during a fetch and all idle cycles.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int H_VISIBLE_AREA = VGA_H_VISIBLE,
  parameter int V_VISIBLE_AREA = VGA_V_VISIBLE,
  parameter int DATA_WIDTH     = 12,
  parameter int ADDR_WIDTH     = 19,
  parameter int WRITER_SLOT    = 8
) (
  input  logic                              VGA_CLK,
  input  logic                              VGA_RESET,
  input  logic                              fetch_req,
  input  logic [$clog2(V_VISIBLE_AREA)-1:0] fetch_line,
  output logic                              fetch_busy,
  output logic                              fetch_done,
  output logic                              fetch_err,
  output logic                              lb_bank,
  output logic                              lb_we,
  output logic [$clog2(H_VISIBLE_AREA)-1:0] lb_addr,
  output logic [DATA_WIDTH-1:0]             lb_wdata,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [ADDR_WIDTH-1:0]             wr_addr,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic                              mem_we,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  input  logic [DATA_WIDTH-1:0]             mem_rdata
);

  localparam int PIX_W    = $clog2(H_VISIBLE_AREA);
  localparam int LINE_W   = $clog2(V_VISIBLE_AREA);
  localparam int FB_WORDS = H_VISIBLE_AREA * V_VISIBLE_AREA;

  localparam logic [PIX_W-1:0]    LAST_PIX   = PIX_W'(H_VISIBLE_AREA - 1);
  localparam logic [LINE_W:0]     LINE_LIMIT = (LINE_W + 1)'(V_VISIBLE_AREA);
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(FB_WORDS);

  fetch_state_t          state, next_state;
  logic [ADDR_WIDTH-1:0] base;
  logic [PIX_W-1:0]      pix;
  logic                  rd_issue;
  logic                  rd_pending;
  logic                  slot;
  logic                  line_ok;
  logic                  accept;
  logic                  wr_in_range;

  assign line_ok     = {1'b0, fetch_line} < LINE_LIMIT;
  assign accept      = (state == IDLE) && fetch_req && line_ok;
  assign wr_in_range = {1'b0, wr_addr} < ADDR_LIMIT;

  vga_slot_counter #(
    .WRITER_SLOT(WRITER_SLOT)
  ) u_slot_counter (
    .clk   (VGA_CLK),
    .reset (VGA_RESET),
    .clear (accept),
    .enable(state == FETCH),
    .slot  (slot)
  );

  always_ff @(posedge VGA_CLK) begin
    if (VGA_RESET) begin
      state      <= IDLE;
      base       <= '0;
      pix        <= '0;
      lb_bank    <= 1'b0;
      fetch_err  <= 1'b0;
      rd_pending <= 1'b0;
      lb_addr    <= '0;
    end else begin
      state      <= next_state;
      rd_pending <= rd_issue;
      if (rd_issue) begin
        lb_addr <= pix;
        pix     <= pix + 1'b1;
      end
      // Any request that cannot start a fetch is dropped and flagged.
      if (accept) begin
        base    <= ADDR_WIDTH'(fetch_line) * ADDR_WIDTH'(H_VISIBLE_AREA);
        pix     <= '0;
        lb_bank <= ~lb_bank;
      end else if (fetch_req) begin
        fetch_err <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    wr_ready   = 1'b0;
    rd_issue   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        wr_ready = 1'b1;
        if (accept) next_state = FETCH;
      end
      FETCH: begin
        wr_ready = slot;
        if (!(slot && wr_valid)) begin
          rd_issue = 1'b1;
          mem_addr = base + ADDR_WIDTH'(pix);
          if (pix == LAST_PIX) next_state = DRAIN;
        end
      end
      DRAIN:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // Out-of-range writes still complete the handshake but never reach the RAM.
    if (wr_ready && wr_valid && wr_in_range) begin
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end
  end

  assign fetch_busy = (state != IDLE);
  assign fetch_done = (state == DRAIN);
  assign lb_we      = rd_pending;
  assign lb_wdata   = rd_pending ? mem_rdata : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter on a small 8x3 framebuffer with a
// writer slot every 4th fetch cycle; line 3 and address 31 are out of range.
module tb_vga_fb_arbiter;

  localparam int H  = 8;
  localparam int V  = 3;
  localparam int DW = 12;
  localparam int AW = 5;
  localparam int WS = 4;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  logic          clk = 1'b0;
  logic          VGA_RESET;
  logic          fetch_req;
  logic [1:0]    fetch_line;
  logic          fetch_busy, fetch_done, fetch_err;
  logic          lb_bank, lb_we;
  logic [2:0]    lb_addr;
  logic [DW-1:0] lb_wdata;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] ram [0:31];
  logic          ram_init;

  exp_t lb_q[$];
  exp_t mem_q[$];
  int   total = 0;
  int   bad   = 0;

  vga_fb_arbiter #(
    .H_VISIBLE_AREA(H),
    .V_VISIBLE_AREA(V),
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .WRITER_SLOT   (WS)
  ) dut (
    .VGA_CLK   (clk),
    .VGA_RESET (VGA_RESET),
    .fetch_req (fetch_req),
    .fetch_line(fetch_line),
    .fetch_busy(fetch_busy),
    .fetch_done(fetch_done),
    .fetch_err (fetch_err),
    .lb_bank   (lb_bank),
    .lb_we     (lb_we),
    .lb_addr   (lb_addr),
    .lb_wdata  (lb_wdata),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Framebuffer model: one-cycle read latency, preloaded with RAM[i]=i.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 32; i++) ram[i] <= DW'(i);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor pops an expectation whenever the DUT writes the line buffer or RAM.
  always @(negedge clk) begin
    if (lb_we === 1'b1) begin
      if (lb_q.size() == 0) begin
        checkOutput("lb_we_unexpected", lb_q.size(), 1);
      end else begin
        exp_t e;
        e = lb_q.pop_front();
        checkOutput("lb_addr", lb_addr, e.addr);
        checkOutput("lb_wdata", lb_wdata, e.data);
      end
    end
    if (mem_we === 1'b1) begin
      if (mem_q.size() == 0) begin
        checkOutput("mem_we_unexpected", mem_q.size(), 1);
      end else begin
        exp_t e;
        e = mem_q.pop_front();
        checkOutput("mem_addr_wr", mem_addr, e.addr);
        checkOutput("mem_wdata", mem_wdata, e.data);
      end
    end
  end

  // Line contents after the writes to RAM[3] and RAM[5] earlier in the run.
  function automatic int exp_pixel(input int line, input int p);
    if (line == 0 && p == 3) return 'hABC;
    if (line == 0 && p == 5) return 'h155;
    return line * H + p;
  endfunction

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_busy"}, fetch_busy, 0);
    checkOutput({tag, "_done"}, fetch_done, 0);
    checkOutput({tag, "_err"}, fetch_err, 0);
    checkOutput({tag, "_bank"}, lb_bank, 0);
    checkOutput({tag, "_lb_we"}, lb_we, 0);
    checkOutput({tag, "_lb_addr"}, lb_addr, 0);
    checkOutput({tag, "_lb_wdata"}, lb_wdata, 0);
    checkOutput({tag, "_mem_we"}, mem_we, 0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic applyStimulus(input int line, input bit wr_hold, input bit wr_at_accept,
                               input int busy_req_at, input int reset_at,
                               input int exp_done, input int n_lb);
    int done_k;
    for (int p = 0; p < n_lb; p++) lb_q.push_back('{p, exp_pixel(line, p)});
    @(posedge clk);
    #1;
    fetch_req  = 1'b1;
    fetch_line = 2'(line);
    wr_valid   = wr_at_accept;
    @(negedge clk);
    done_k = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      fetch_req  = (k == busy_req_at);
      fetch_line = (k == busy_req_at) ? 2'd0 : 2'(line);
      wr_valid   = wr_hold;
      VGA_RESET  = (reset_at != 0) && (k == reset_at);
      @(negedge clk);
      if (k == 1) begin
        checkOutput("first_read_addr", mem_addr, line * H);
        checkOutput("busy_in_fetch", fetch_busy, 1);
      end
      if (reset_at != 0 && k == reset_at + 1) begin
        checkIdleZero("after_reset");
        break;
      end
      if (fetch_done) begin
        done_k = k;
        break;
      end
    end
    fetch_req = 1'b0;
    wr_valid  = 1'b0;
    VGA_RESET = 1'b0;
    if (reset_at == 0) checkOutput("done_latency", done_k, exp_done);
    if (busy_req_at != 0) checkOutput("err_busy_req", fetch_err, 1);
  endtask

  initial begin
    bit seen_done;
    VGA_RESET  = 1'b1;
    ram_init   = 1'b1;
    fetch_req  = 1'b0;
    fetch_line = '0;
    wr_valid   = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    repeat (3) @(posedge clk);
    #1;
    ram_init = 1'b0;
    @(negedge clk);
    checkIdleZero("reset");
    @(posedge clk);
    #1;
    VGA_RESET = 1'b0;
    @(negedge clk);

    // Plain fetch of line 2: 8 reads, done 9 cycles after acceptance.
    applyStimulus(2, 1'b0, 1'b0, 0, 0, 9, 8);
    checkOutput("bank_fetch1", lb_bank, 1);

    // Writer held: slots at fetch cycles 3 and 7 steal two read cycles.
    wr_addr = 5'd3;
    wr_data = 12'hABC;
    mem_q.push_back('{3, 'hABC});
    mem_q.push_back('{3, 'hABC});
    applyStimulus(2, 1'b1, 1'b0, 0, 0, 11, 8);
    checkOutput("bank_fetch2", lb_bank, 0);
    checkOutput("ram3_written", ram[3], 'hABC);

    // Write and fetch request together in IDLE.
    wr_addr = 5'd5;
    wr_data = 12'h155;
    mem_q.push_back('{5, 'h155});
    applyStimulus(1, 1'b0, 1'b1, 0, 0, 9, 8);
    checkOutput("bank_fetch3", lb_bank, 1);
    checkOutput("ram5_written", ram[5], 'h155);

    // Out-of-range writer address: handshake only.
    @(posedge clk);
    #1;
    wr_valid = 1'b1;
    wr_addr  = 5'd31;
    wr_data  = 12'hFFF;
    @(negedge clk);
    checkOutput("oor_wr_ready", wr_ready, 1);
    checkOutput("oor_mem_we", mem_we, 0);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    @(negedge clk);
    checkOutput("oor_ram31", ram[31], 31);

    // Out-of-range line request.
    @(posedge clk);
    #1;
    fetch_req  = 1'b1;
    fetch_line = 2'd3;
    @(negedge clk);
    checkOutput("err_before", fetch_err, 0);
    @(posedge clk);
    #1;
    fetch_req = 1'b0;
    @(negedge clk);
    checkOutput("err_bad_line", fetch_err, 1);
    checkOutput("busy_bad_line", fetch_busy, 0);
    checkOutput("bank_bad_line", lb_bank, 1);

    // Reset while issuing pixel 4 aborts the fetch silently.
    applyStimulus(2, 1'b0, 1'b0, 0, 5, 0, 4);
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (fetch_done) seen_done = 1'b1;
    end
    checkOutput("no_done_after_reset", seen_done, 0);
    applyStimulus(0, 1'b0, 1'b0, 0, 0, 9, 8);
    checkOutput("bank_after_reset", lb_bank, 1);

    // Request during a fetch is flagged and ignored.
    applyStimulus(1, 1'b0, 1'b0, 3, 0, 9, 8);
    checkOutput("bank_busy_req", lb_bank, 0);
    repeat (3) @(negedge clk);
    checkOutput("err_sticky", fetch_err, 1);
    checkOutput("idle_after_busy_req", fetch_busy, 0);

    checkOutput("lb_q_left", lb_q.size(), 0);
    checkOutput("mem_q_left", mem_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
